axi_rd_arbiter: RTL and testbench

- Shares the core's single AXI read port between the I-cache refill path and the D-cache refill/uncached-load path.
- Allows one outstanding burst at a time.
- Selects a winner, drives the AR channel from registered values, and routes R beats back to the owner.
- Requester-side waits are what the caches turn into i_stall / d_stall for the pipeline hazard unit.

---
 rtl/cdim_axi_pkg.sv | 46 ++++
 rtl/arb_pick2.sv | 55 +++++
 rtl/axi_rd_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdim_axi_pkg.sv
// ============================================================================
// Module      : cdim_axi_pkg
// Description : Shared AXI read-side types and constants for the core's
//               bus arbitration logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdim_axi_pkg;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_t;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam int         ID_INST_DEF = 0;
   localparam int         ID_DATA_DEF = 1;

   // AXI arsize encoding: log2 of the bytes per beat.
   function automatic logic [2:0] axi_size(input int data_w);
      logic [2:0] s;
      s = 3'd0;
      case (data_w)
         8:       s = 3'd0;
         16:      s = 3'd1;
         32:      s = 3'd2;
         64:      s = 3'd3;
         128:     s = 3'd4;
         256:     s = 3'd5;
         512:     s = 3'd6;
         1024:    s = 3'd7;
         default: s = 3'd0;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick2.sv
// ============================================================================
// Module      : arb_pick2
// Description : Two-way requester picker. Fixed data-over-inst priority by
//               default; round-robin with a last_owner register when ARB_RR_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick2
   import cdim_axi_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   req_inst,
   input  logic   req_data,
   input  logic   take,
   output logic   any_req,
   output owner_t winner
);

   assign any_req = req_inst | req_data;

`ifdef ARB_RR_EN
   owner_t r_last_owner;

   // Reset to INST so the first tie goes to the data side.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_owner <= OWN_INST;
      end else if (take && any_req) begin
         r_last_owner <= winner;
      end
   end

   always_comb begin
      winner = OWN_INST;
      if (req_inst && req_data) begin
         winner = (r_last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
      end else if (req_data) begin
         winner = OWN_DATA;
      end
   end
`else
   logic w_unused_pick;
   assign w_unused_pick = &{1'b0, clk, rst, take};

   always_comb begin
      winner = req_data ? OWN_DATA : OWN_INST;
   end
`endif

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI read port between I-cache and D-cache, one
//               outstanding burst at a time. Optional macro: ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter
   import cdim_axi_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 4,
   parameter int ID_W    = 4,
   parameter int ID_INST = ID_INST_DEF,
   parameter int ID_DATA = ID_DATA_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [LEN_W-1:0]  inst_len,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_rlast,
   output logic              inst_rerr,

   input  logic              data_req,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [LEN_W-1:0]  data_len,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_rlast,
   output logic              data_rerr,

   output logic [ID_W-1:0]   arid,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,

   input  logic [ID_W-1:0]   rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,

   output logic              busy
);

   localparam logic [ID_W-1:0] C_ARID_INST = ID_W'(ID_INST);
   localparam logic [ID_W-1:0] C_ARID_DATA = ID_W'(ID_DATA);
   localparam logic [2:0]      C_ARSIZE    = axi_size(DATA_W);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   owner_t            r_owner;
   owner_t            w_winner;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_beat_cnt;
   logic              r_past_end;
   logic              r_len_mismatch;
   logic              w_any_req;
   logic              w_take;
   logic              w_r_beat;
   logic              w_r_done;
   logic              w_unused_rid;

   // Routing is by latched owner only; rid is deliberately ignored.
   assign w_unused_rid = &{1'b0, rid};

   assign w_take   = (r_state == ARB_IDLE);
   assign w_r_beat = (r_state == ARB_DATA) && rvalid;
   assign w_r_done = w_r_beat && rlast;

   arb_pick2 u_pick (
      .clk      (clk),
      .rst      (rst),
      .req_inst (inst_req),
      .req_data (data_req),
      .take     (w_take),
      .any_req  (w_any_req),
      .winner   (w_winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE: if (w_any_req) w_next_state = ARB_ADDR;
         ARB_ADDR: if (arready)   w_next_state = ARB_DATA;
         ARB_DATA: if (w_r_done)  w_next_state = ARB_IDLE;
         default:                 w_next_state = ARB_IDLE;
      endcase
   end

   // Burst fields are captured only in IDLE, so AR stays stable while arvalid is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner <= OWN_INST;
         r_addr  <= '0;
         r_len   <= '0;
      end else if (w_take && w_any_req) begin
         r_owner <= w_winner;
         r_addr  <= (w_winner == OWN_DATA) ? data_addr : inst_addr;
         r_len   <= (w_winner == OWN_DATA) ? data_len  : inst_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt     <= '0;
         r_past_end     <= 1'b0;
         r_len_mismatch <= 1'b0;
      end else if (w_take) begin
         r_beat_cnt     <= '0;
         r_past_end     <= 1'b0;
         r_len_mismatch <= 1'b0;
      end else if (w_r_beat) begin
         if (r_past_end || (rlast != (r_beat_cnt == r_len))) begin
            r_len_mismatch <= 1'b1;
         end
         if (r_beat_cnt == r_len) begin
            r_past_end <= 1'b1;
         end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) !r_len_mismatch)
      else $error("read burst length does not match latched len");

   assign arid    = (r_owner == OWN_DATA) ? C_ARID_DATA : C_ARID_INST;
   assign araddr  = r_addr;
   assign arlen   = 8'(r_len);
   assign arsize  = C_ARSIZE;
   assign arburst = BURST_INCR;

   assign inst_rdata = rdata;
   assign data_rdata = rdata;

   always_comb begin
      arvalid     = 1'b0;
      rready      = 1'b0;
      busy        = 1'b0;
      inst_gnt    = 1'b0;
      data_gnt    = 1'b0;
      inst_rvalid = 1'b0;
      inst_rlast  = 1'b0;
      inst_rerr   = 1'b0;
      data_rvalid = 1'b0;
      data_rlast  = 1'b0;
      data_rerr   = 1'b0;
      case (r_state)
         ARB_ADDR: begin
            arvalid  = 1'b1;
            busy     = 1'b1;
            inst_gnt = arready && (r_owner == OWN_INST);
            data_gnt = arready && (r_owner == OWN_DATA);
         end
         ARB_DATA: begin
            rready = 1'b1;
            busy   = 1'b1;
            if (r_owner == OWN_DATA) begin
               data_rvalid = rvalid;
               data_rlast  = rvalid && rlast;
               data_rerr   = rvalid && (|rresp);
            end else begin
               inst_rvalid = rvalid;
               inst_rlast  = rvalid && rlast;
               inst_rerr   = rvalid && (|rresp);
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Scoreboard bench for axi_rd_arbiter; expected AR handshakes
//               and R beats are queued in order and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req = 1'b0, data_req = 1'b0;
   logic [31:0] inst_addr = '0, data_addr = '0;
   logic [3:0]  inst_len = '0, data_len = '0;
   logic        inst_gnt, inst_rvalid, inst_rlast, inst_rerr;
   logic        data_gnt, data_rvalid, data_rlast, data_rerr;
   logic [31:0] inst_rdata, data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid, arready = 1'b0;
   logic [3:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0, rvalid = 1'b0, rready, busy;

   axi_rd_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len),
      .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .inst_rlast(inst_rlast), .inst_rerr(inst_rerr),
      .data_req(data_req), .data_addr(data_addr), .data_len(data_len),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .data_rlast(data_rlast), .data_rerr(data_rerr),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_ar;
      bit          own_data;
      logic [31:0] val;
      logic [7:0]  len;
      bit          last;
      bit          err;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ar(input bit d, input logic [31:0] a, input logic [7:0] l);
      exp_t e;
      e.is_ar = 1'b1; e.own_data = d; e.val = a; e.len = l; e.last = 1'b0; e.err = 1'b0;
      q.push_back(e);
   endtask

   task automatic push_beat(input bit d, input logic [31:0] v, input bit l, input bit er);
      exp_t e;
      e.is_ar = 1'b0; e.own_data = d; e.val = v; e.len = 8'd0; e.last = l; e.err = er;
      q.push_back(e);
   endtask

   task automatic ar_accept(input int delay);
      int n = 0;
      while (!arvalid && n < 50) begin
         step();
         n++;
      end
      chk("arvalid_seen", {31'b0, arvalid}, 32'd1);
      repeat (delay) step();
      arready = 1'b1;
      step();
      arready = 1'b0;
   endtask

   task automatic beats(input bit d, input int n, input logic [31:0] base, input int err_idx);
      for (int b = 0; b < n; b++) begin
         rvalid = 1'b1;
         rdata  = base + 32'(b);
         rresp  = (b == err_idx) ? 2'b10 : 2'b00;
         rlast  = (b == n - 1);
         rid    = d ? 4'd1 : 4'd0;
         push_beat(d, base + 32'(b), (b == n - 1), (b == err_idx));
         step();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
   endtask

   // Monitor: every AR handshake and every routed beat pops one expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (arvalid && arready) begin
            if (q.size() == 0 || !q[0].is_ar) begin
               checks++; errors++;
               $display("FAIL ar_unexpected: got araddr %h expected no AR handshake", araddr);
            end else begin
               me = q.pop_front();
               chk("arid",     {28'b0, arid},      me.own_data ? 32'd1 : 32'd0);
               chk("araddr",   araddr,             me.val);
               chk("arlen",    {24'b0, arlen},     {24'b0, me.len});
               chk("arsize",   {29'b0, arsize},    32'd2);
               chk("arburst",  {30'b0, arburst},   32'd1);
               chk("gnt_pair", {30'b0, inst_gnt, data_gnt}, me.own_data ? 32'd1 : 32'd2);
            end
         end else if (inst_gnt || data_gnt) begin
            checks++; errors++;
            $display("FAIL stray_gnt: got inst %b data %b expected 0 0", inst_gnt, data_gnt);
         end
         if (inst_rvalid || data_rvalid) begin
            if (q.size() == 0 || q[0].is_ar) begin
               checks++; errors++;
               $display("FAIL beat_unexpected: got rvalid inst %b data %b expected none", inst_rvalid, data_rvalid);
            end else begin
               me = q.pop_front();
               chk("beat_route", {30'b0, inst_rvalid, data_rvalid}, me.own_data ? 32'd1 : 32'd2);
               chk("beat_data", me.own_data ? data_rdata : inst_rdata, me.val);
               chk("beat_last", {31'b0, me.own_data ? data_rlast : inst_rlast}, {31'b0, me.last});
               chk("beat_err",  {31'b0, me.own_data ? data_rerr  : inst_rerr},  {31'b0, me.err});
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      rst = 1'b0;
      chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
      chk("rst_rready",  {31'b0, rready},  32'd0);
      chk("rst_busy",    {31'b0, busy},    32'd0);
      chk("rst_gnt",     {30'b0, inst_gnt, data_gnt}, 32'd0);
      chk("rst_rvalid",  {30'b0, inst_rvalid, data_rvalid}, 32'd0);
      chk("rst_araddr",  araddr, 32'd0);
      mon_en = 1'b1;
      step();

      // Lone instruction burst, arready after 2 cycles.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_len = 4'd3;
      chk("t1_ar_pre", {31'b0, arvalid}, 32'd0);
      push_ar(1'b0, 32'hBFC0_0000, 8'd3);
      step();
      chk("t1_ar_latency", {31'b0, arvalid}, 32'd1);
      ar_accept(2);
      inst_req = 1'b0;
      beats(1'b0, 4, 32'h1000_0000, -1);
      chk("t1_busy_done", {31'b0, busy}, 32'd0);

      // Simultaneous requests: data first, then inst after one IDLE bubble.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0040; inst_len = 4'd1;
      data_req = 1'b1; data_addr = 32'h8000_1000; data_len = 4'd0;
      push_ar(1'b1, 32'h8000_1000, 8'd0);
      ar_accept(0);
      data_req = 1'b0;
      beats(1'b1, 1, 32'hD000_0000, -1);
      chk("t2_bubble_idle", {31'b0, arvalid}, 32'd0);
      push_ar(1'b0, 32'hBFC0_0040, 8'd1);
      step();
      chk("t2_bubble_addr", {31'b0, arvalid}, 32'd1);
      ar_accept(1);
      inst_req = 1'b0;
      beats(1'b0, 2, 32'h2000_0000, -1);

      // Error response on the second beat of a data burst.
      data_req = 1'b1; data_addr = 32'h8000_0040; data_len = 4'd3;
      push_ar(1'b1, 32'h8000_0040, 8'd3);
      ar_accept(0);
      data_req = 1'b0;
      beats(1'b1, 4, 32'hE000_0000, 1);

      // AR fields stay stable while arready is held low and data_addr moves.
      data_req = 1'b1; data_addr = 32'h8000_3000; data_len = 4'd0;
      push_ar(1'b1, 32'h8000_3000, 8'd0);
      step();
      for (int i = 0; i < 10; i++) begin
         data_addr = 32'h8000_3000 + 32'((i + 1) * 4);
         step();
         chk("t4_araddr_hold", araddr, 32'h8000_3000);
      end
      ar_accept(0);
      data_req = 1'b0;
      beats(1'b1, 1, 32'hA000_0000, -1);

      // Reset during beat 2 of a data burst.
      data_req = 1'b1; data_addr = 32'h8000_4000; data_len = 4'd3;
      push_ar(1'b1, 32'h8000_4000, 8'd3);
      ar_accept(0);
      data_req = 1'b0;
      rvalid = 1'b1; rdata = 32'hF000_0000; rlast = 1'b0; rresp = 2'b00;
      push_beat(1'b1, 32'hF000_0000, 1'b0, 1'b0);
      step();
      rdata = 32'hF000_0001;
      push_beat(1'b1, 32'hF000_0001, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rvalid = 1'b0;
      rst = 1'b0;
      chk("t5_arvalid", {31'b0, arvalid}, 32'd0);
      chk("t5_rready",  {31'b0, rready},  32'd0);
      chk("t5_busy",    {31'b0, busy},    32'd0);
      inst_req = 1'b1; inst_addr = 32'hBFC0_0080; inst_len = 4'd0;
      push_ar(1'b0, 32'hBFC0_0080, 8'd0);
      ar_accept(0);
      inst_req = 1'b0;
      beats(1'b0, 1, 32'h3000_0000, -1);

      // Continuous data requests with a pending instruction request.
      data_req = 1'b1; data_addr = 32'h8000_2000; data_len = 4'd0;
      inst_req = 1'b1; inst_addr = 32'hBFC0_0100; inst_len = 4'd0;
`ifdef ARB_RR_EN
      push_ar(1'b1, 32'h8000_2000, 8'd0);
      ar_accept(0);
      beats(1'b1, 1, 32'hC000_0000, -1);
      push_ar(1'b0, 32'hBFC0_0100, 8'd0);
      ar_accept(0);
      inst_req = 1'b0;
      beats(1'b0, 1, 32'hC000_0001, -1);
      push_ar(1'b1, 32'h8000_2000, 8'd0);
      ar_accept(0);
      data_req = 1'b0;
      beats(1'b1, 1, 32'hC000_0002, -1);
`else
      push_ar(1'b1, 32'h8000_2000, 8'd0);
      ar_accept(0);
      beats(1'b1, 1, 32'hC000_0000, -1);
      push_ar(1'b1, 32'h8000_2000, 8'd0);
      ar_accept(0);
      data_req = 1'b0;
      beats(1'b1, 1, 32'hC000_0001, -1);
      push_ar(1'b0, 32'hBFC0_0100, 8'd0);
      ar_accept(0);
      inst_req = 1'b0;
      beats(1'b0, 1, 32'hC000_0002, -1);
`endif

      repeat (3) step();
      chk("queue_empty", 32'(q.size()), 32'd0);
      chk("final_busy", {31'b0, busy}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
